// File: rtl/uart_echo_buffer_if.sv
// Echo-buffer bus: RX strobe/byte in, TX strobe/byte out, plus display taps.
// The slave modport is the echo engine; the master modport is its environment.
interface uart_echo_buffer_if #(
   parameter int DEPTH       = 16,
   parameter int COUNT_WIDTH = 8
);
   localparam int FILL_W = $clog2(DEPTH) + 1;

   logic                   i_RX_DV;
   logic [7:0]             i_RX_Byte;
   logic [1:0]             i_Mode;
   logic                   i_TX_Active;
   logic                   i_TX_Done;
   logic                   o_TX_DV;
   logic [7:0]             o_TX_Byte;
   logic [7:0]             o_Last_Byte;
   logic [COUNT_WIDTH-1:0] o_Count;
   logic [FILL_W-1:0]      o_Fill;
   logic                   o_Overflow;

   modport slave (
      input  i_RX_DV, i_RX_Byte, i_Mode, i_TX_Active, i_TX_Done,
      output o_TX_DV, o_TX_Byte, o_Last_Byte, o_Count, o_Fill, o_Overflow
   );

   modport master (
      output i_RX_DV, i_RX_Byte, i_Mode, i_TX_Active, i_TX_Done,
      input  o_TX_DV, o_TX_Byte, o_Last_Byte, o_Count, o_Fill, o_Overflow
   );
endinterface

// File: rtl/uart_echo_buffer.sv
// Byte FIFO between UART RX and TX with raw/uppercase/hex/silent echo; TX strobe 2 cycles after RX into an idle path.
// Backpressure: pops only while the transmitter is idle; RX bytes arriving on a full FIFO are dropped and flagged.
module uart_echo_buffer #(
   parameter int DEPTH       = 16,
   parameter int COUNT_WIDTH = 8
) (
   input logic               i_Clk,
   input logic               i_Rst,
   uart_echo_buffer_if.slave bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND1,
      S_WAIT1,
      S_SEND_HI,
      S_WAIT_HI,
      S_GAP,
      S_SEND_LO
   } state_t;

   state_t                 state_q, state_d;
   logic [7:0]             mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic                   overflow_q, overflow_d;
   logic [7:0]             last_byte_q, last_byte_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [7:0]             data_q, data_d;
   logic                   tx_dv_q, tx_dv_d;
   logic [7:0]             tx_byte_q, tx_byte_d;
   logic                   push, pop;
   logic [7:0]             head;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      logic [7:0] n8;
      n8 = {4'h0, n};
      return (n < 4'd10) ? (8'h30 + n8) : (8'h37 + n8);
   endfunction

   function automatic logic [7:0] to_upper(input logic [7:0] b);
      return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
   endfunction

   assign head = mem_q[rd_ptr_q];
   assign pop  = (state_q == S_IDLE) && (fill_q != '0) && !bus.i_TX_Active;
   // A full FIFO still accepts a byte when the same edge frees a slot.
   assign push = bus.i_RX_DV && ((fill_q != FILL_W'(DEPTH)) || pop);

   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      fill_d      = fill_q;
      if (push && !pop)
         fill_d = fill_q + 1'b1;
      else if (pop && !push)
         fill_d = fill_q - 1'b1;
      overflow_d  = overflow_q | (bus.i_RX_DV & ~push);
      last_byte_d = bus.i_RX_DV ? bus.i_RX_Byte : last_byte_q;
      count_d     = count_q + {{(COUNT_WIDTH-1){1'b0}}, bus.i_RX_DV};
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               case (bus.i_Mode)
                  2'd0: begin
                     data_d  = head;
                     state_d = S_SEND1;
                  end
                  2'd1: begin
                     data_d  = to_upper(head);
                     state_d = S_SEND1;
                  end
                  2'd2: begin
                     data_d  = head;
                     state_d = S_SEND_HI;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_SEND1: begin
            tx_dv_d   = 1'b1;
            tx_byte_d = data_q;
            state_d   = S_WAIT1;
         end
         S_WAIT1: begin
            if (bus.i_TX_Done)
               state_d = S_IDLE;
         end
         S_SEND_HI: begin
            tx_dv_d   = 1'b1;
            tx_byte_d = hex_char(data_q[7:4]);
            state_d   = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (bus.i_TX_Done)
               state_d = S_GAP;
         end
         S_GAP: begin
            if (!bus.i_TX_Active)
               state_d = S_SEND_LO;
         end
         S_SEND_LO: begin
            tx_dv_d   = 1'b1;
            tx_byte_d = hex_char(data_q[3:0]);
            state_d   = S_WAIT1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (push)
         mem_q[wr_ptr_q] <= bus.i_RX_Byte;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         overflow_q  <= 1'b0;
         last_byte_q <= 8'h00;
         count_q     <= '0;
         data_q      <= 8'h00;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         overflow_q  <= overflow_d;
         last_byte_q <= last_byte_d;
         count_q     <= count_d;
         data_q      <= data_d;
         tx_dv_q     <= tx_dv_d;
         tx_byte_q   <= tx_byte_d;
      end
   end

   assign bus.o_TX_DV     = tx_dv_q;
   assign bus.o_TX_Byte   = tx_byte_q;
   assign bus.o_Last_Byte = last_byte_q;
   assign bus.o_Count     = count_q;
   assign bus.o_Fill      = fill_q;
   assign bus.o_Overflow  = overflow_q;
endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer with a simple UART transmitter model.
// Each strobe seen on o_TX_DV is logged; the model stays busy 4 cycles, then pulses done.
module tb_uart_echo_buffer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst       = 1'b1;
   logic       rx_dv     = 1'b0;
   logic [7:0] rx_byte   = 8'h00;
   logic [1:0] mode      = 2'd0;
   logic       hold_busy = 1'b0;
   logic       tx_act    = 1'b0;
   logic       tx_done   = 1'b0;
   int         tx_cnt    = 0;
   logic [7:0] tx_q [$];

   int checks = 0;
   int errors = 0;
   int base;

   uart_echo_buffer_if #(.DEPTH(16), .COUNT_WIDTH(8)) bus ();

   uart_echo_buffer #(.DEPTH(16), .COUNT_WIDTH(8)) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus)
   );

   assign bus.i_RX_DV     = rx_dv;
   assign bus.i_RX_Byte   = rx_byte;
   assign bus.i_Mode      = mode;
   assign bus.i_TX_Active = tx_act | hold_busy;
   assign bus.i_TX_Done   = tx_done;

   always @(negedge clk) begin
      tx_done = 1'b0;
      if (bus.o_TX_DV) begin
         tx_q.push_back(bus.o_TX_Byte);
         tx_cnt = 4;
         tx_act = 1'b1;
      end else if (tx_cnt > 0) begin
         tx_cnt = tx_cnt - 1;
         if (tx_cnt == 0) begin
            tx_act  = 1'b0;
            tx_done = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one RX strobe; returns 1 time unit after the sampling edge.
   task automatic send_rx(input logic [7:0] b);
      rx_dv   = 1'b1;
      rx_byte = b;
      tick(1);
      rx_dv   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int budget);
      int i;
      i = 0;
      while (tx_q.size() < n && i < budget) begin
         tick(1);
         i++;
      end
   endtask

   initial begin
      tick(2);
      check("rst_tx_dv",    32'(bus.o_TX_DV),     32'h0);
      check("rst_tx_byte",  32'(bus.o_TX_Byte),   32'h0);
      check("rst_last",     32'(bus.o_Last_Byte), 32'h0);
      check("rst_count",    32'(bus.o_Count),     32'h0);
      check("rst_fill",     32'(bus.o_Fill),      32'h0);
      check("rst_overflow", 32'(bus.o_Overflow),  32'h0);
      rst = 1'b0;

      // Raw echo with cycle-exact latency
      mode = 2'd0;
      base = tx_q.size();
      send_rx(8'h41);
      check("raw_fill_k",   32'(bus.o_Fill),      32'd1);
      check("raw_last",     32'(bus.o_Last_Byte), 32'h41);
      check("raw_count",    32'(bus.o_Count),     32'd1);
      tick(1);
      check("raw_fill_k1",  32'(bus.o_Fill),      32'd0);
      check("raw_dv_k1",    32'(bus.o_TX_DV),     32'h0);
      tick(1);
      check("raw_dv_k2",    32'(bus.o_TX_DV),     32'h1);
      check("raw_byte_k2",  32'(bus.o_TX_Byte),   32'h41);
      tick(1);
      check("raw_dv_k3",    32'(bus.o_TX_DV),     32'h0);
      check("raw_hold",     32'(bus.o_TX_Byte),   32'h41);
      tick(10);
      check("raw_n_tx",     32'(tx_q.size()),     32'(base + 1));

      // Uppercase, back-to-back
      mode = 2'd1;
      base = tx_q.size();
      send_rx(8'h61);
      send_rx(8'h7A);
      send_rx(8'h7B);
      send_rx(8'h5A);
      wait_tx(base + 4, 200);
      tick(15);
      check("up_n_tx", 32'(tx_q.size()), 32'(base + 4));
      if (tx_q.size() >= base + 4) begin
         check("up_0", 32'(tx_q[base]),     32'h41);
         check("up_1", 32'(tx_q[base + 1]), 32'h5A);
         check("up_2", 32'(tx_q[base + 2]), 32'h7B);
         check("up_3", 32'(tx_q[base + 3]), 32'h5A);
      end

      // Hex dump of 0xA5
      mode = 2'd2;
      base = tx_q.size();
      send_rx(8'hA5);
      wait_tx(base + 2, 100);
      tick(20);
      check("hex_n_tx", 32'(tx_q.size()), 32'(base + 2));
      if (tx_q.size() >= base + 2) begin
         check("hex_hi", 32'(tx_q[base]),     32'h41);
         check("hex_lo", 32'(tx_q[base + 1]), 32'h35);
      end
      check("hex_count", 32'(bus.o_Count), 32'd6);

      // Overflow: 17 bytes into a stalled 16-deep FIFO
      do_reset();
      mode      = 2'd0;
      hold_busy = 1'b1;
      for (int i = 1; i <= 17; i++) send_rx(8'(i));
      tick(2);
      check("ovf_fill",  32'(bus.o_Fill),      32'd16);
      check("ovf_flag",  32'(bus.o_Overflow),  32'h1);
      check("ovf_count", 32'(bus.o_Count),     32'd17);
      check("ovf_last",  32'(bus.o_Last_Byte), 32'd17);
      base      = tx_q.size();
      hold_busy = 1'b0;
      wait_tx(base + 16, 400);
      tick(20);
      check("ovf_n_tx", 32'(tx_q.size()), 32'(base + 16));
      if (tx_q.size() >= base + 16)
         for (int i = 0; i < 16; i++) check($sformatf("ovf_b%0d", i), 32'(tx_q[base + i]), 32'(i + 1));
      check("ovf_sticky", 32'(bus.o_Overflow), 32'h1);

      // Full FIFO with push and pop on the same edge
      do_reset();
      hold_busy = 1'b1;
      for (int i = 0; i < 16; i++) send_rx(8'(8'h10 + i));
      check("fp_fill_pre", 32'(bus.o_Fill), 32'd16);
      base      = tx_q.size();
      hold_busy = 1'b0;
      send_rx(8'hEE);
      check("fp_fill",     32'(bus.o_Fill),     32'd16);
      check("fp_overflow", 32'(bus.o_Overflow), 32'h0);
      check("fp_count",    32'(bus.o_Count),    32'd17);
      wait_tx(base + 17, 500);
      tick(20);
      check("fp_n_tx", 32'(tx_q.size()), 32'(base + 17));
      if (tx_q.size() >= base + 17) begin
         check("fp_first", 32'(tx_q[base]),      32'h10);
         check("fp_last",  32'(tx_q[base + 16]), 32'hEE);
      end

      // Reset while waiting on the high hex nibble with 3 bytes queued
      do_reset();
      mode = 2'd2;
      send_rx(8'hA5);
      send_rx(8'h01);
      send_rx(8'h02);
      send_rx(8'h03);
      check("mr_fill_pre", 32'(bus.o_Fill), 32'd3);
      check("mr_hi_sent",  32'(tx_q[tx_q.size() - 1]), 32'h41);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      base = tx_q.size();
      check("mr_fill",  32'(bus.o_Fill),  32'd0);
      check("mr_count", 32'(bus.o_Count), 32'd0);
      check("mr_dv",    32'(bus.o_TX_DV), 32'h0);
      mode = 2'd3;
      send_rx(8'h30);
      tick(30);
      check("mr_no_tx",  32'(tx_q.size()),      32'(base));
      check("mr_count1", 32'(bus.o_Count),     32'd1);
      check("mr_last",   32'(bus.o_Last_Byte), 32'h30);
      check("mr_drain",  32'(bus.o_Fill),      32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
